// File: rtl/saida_display_pkg.sv
// Shared definitions for the signed-value 7-segment output block:
// FSM encoding, active-low segment patterns and conversion limits.
package saida_display_pkg;

   typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;

   // Active-low patterns, bit6..bit0 = g..a
   localparam logic [6:0] SEG_0       = 7'b1000000;
   localparam logic [6:0] SEG_1       = 7'b1111001;
   localparam logic [6:0] SEG_2       = 7'b0100100;
   localparam logic [6:0] SEG_3       = 7'b0110000;
   localparam logic [6:0] SEG_4       = 7'b0011001;
   localparam logic [6:0] SEG_5       = 7'b0010010;
   localparam logic [6:0] SEG_6       = 7'b0000010;
   localparam logic [6:0] SEG_7       = 7'b1111000;
   localparam logic [6:0] SEG_8       = 7'b0000000;
   localparam logic [6:0] SEG_9       = 7'b0010000;
   localparam logic [6:0] SEG_APAGADO = 7'b1111111;
   localparam logic [6:0] SEG_TRACO   = 7'b0111111;

   localparam int unsigned LIMITE = 9999;
   localparam int unsigned PASSOS = 14;

   // One double-dabble step: +3 on every nibble >= 5, then shift in the next bit.
   function automatic logic [15:0] passo_dd(input logic [15:0] bcd, input logic bit_in);
      logic [15:0] aj;
      aj = bcd;
      for (int i = 0; i < 4; i++)
         if (aj[i*4 +: 4] >= 4'd5) aj[i*4 +: 4] = aj[i*4 +: 4] + 4'd3;
      return {aj[14:0], bit_in};
   endfunction

endpackage

// File: rtl/saida_display_decodificador_7seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module decodificador_7seg
   import saida_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_APAGADO;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_APAGADO;
      endcase
   end

endmodule

// File: rtl/saida_display.sv
// Converts a strobed signed 32-bit value to four 7-segment digits plus sign,
// using a serial double-dabble over 14 cycles; displays update atomically.
module saida_display
   import saida_display_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dado_saida,
   input  logic        sinal_saida,
   output logic        ocupado,
   output logic [6:0]  display0,
   output logic [6:0]  display1,
   output logic [6:0]  display2,
   output logic [6:0]  display3,
   output logic [6:0]  display_sinal
);

   estado_t           estado, prox;
   logic [3:0]        cont;
   logic [13:0]       mag;
   logic [15:0]       bcd;
   logic              neg, ovf;
   logic [31:0]       mag_in;
   logic [3:0][6:0]   seg;
   logic [3:1]        apaga;

   // Unsigned magnitude; 0x80000000 negates to itself and lands above the limit.
   assign mag_in  = dado_saida[31] ? (32'd0 - dado_saida) : dado_saida;
   assign ocupado = (estado != OCIOSO);

   always_ff @(posedge clock or negedge reset)
      if (!reset) estado <= OCIOSO;
      else        estado <= prox;

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:   prox = OCIOSO;
         CONVERTE: if (cont == 4'(PASSOS - 1)) prox = ATUALIZA;
         ATUALIZA: prox = OCIOSO;
         default:  prox = OCIOSO;
      endcase
      if (sinal_saida) prox = CONVERTE;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         neg  <= 1'b0;
         ovf  <= 1'b0;
         mag  <= '0;
         bcd  <= '0;
         cont <= '0;
      end else if (sinal_saida) begin
         neg  <= dado_saida[31];
         ovf  <= (mag_in > 32'(LIMITE));
         mag  <= mag_in[13:0];
         bcd  <= '0;
         cont <= '0;
      end else if (estado == CONVERTE) begin
         bcd  <= passo_dd(bcd, mag[13]);
         mag  <= {mag[12:0], 1'b0};
         cont <= cont + 4'd1;
      end

   for (genvar i = 0; i < 4; i++) begin : g_dec
      decodificador_7seg u_dec (.bcd(bcd[i*4 +: 4]), .seg(seg[i]));
   end

   assign apaga[3] = (bcd[15:12] == 4'd0);
   assign apaga[2] = apaga[3] && (bcd[11:8] == 4'd0);
   assign apaga[1] = apaga[2] && (bcd[7:4]  == 4'd0);

   // A strobe landing on the update edge wins, so the stale result is dropped.
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         display0      <= SEG_0;
         display1      <= SEG_APAGADO;
         display2      <= SEG_APAGADO;
         display3      <= SEG_APAGADO;
         display_sinal <= SEG_APAGADO;
      end else if (estado == ATUALIZA && !sinal_saida) begin
         if (ovf) begin
            display0      <= SEG_TRACO;
            display1      <= SEG_TRACO;
            display2      <= SEG_TRACO;
            display3      <= SEG_TRACO;
            display_sinal <= SEG_APAGADO;
         end else begin
            display0      <= seg[0];
            display1      <= apaga[1] ? SEG_APAGADO : seg[1];
            display2      <= apaga[2] ? SEG_APAGADO : seg[2];
            display3      <= apaga[3] ? SEG_APAGADO : seg[3];
            display_sinal <= neg ? SEG_TRACO : SEG_APAGADO;
         end
      end

endmodule

// File: doc/saida_display.md
SAIDA_DISPLAY -- requirements
Module: saida_display

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
  clock  in  1  system clock; all state changes on the rising edge
  reset  in  1  asynchronous, active-low
  dado_saida  in  32  signed two's-complement register value to be displayed
  sinal_saida  in  1  one-cycle OUT strobe from the controller; samples dado_saida
  ocupado  out  1  high while a conversion is in progress
  display0..display3  out  7 each  active-low segments; display0 is the units digit; bit0 = seg a ... bit6 = seg g
  display_sinal  out  7  active-low sign display

Function
REQ-003 The FSM SHALL have exactly three states: OCIOSO, CONVERTE, ATUALIZA.
REQ-004 On an edge with sinal_saida=1, in any state, the block SHALL capture the sign bit and the 32-bit magnitude of dado_saida, clear the BCD accumulator, set the bit counter to 0, and enter CONVERTE.
REQ-005 Overflow SHALL be flagged at capture when magnitude > 9999; -2147483648 SHALL be treated as overflow.
REQ-006 In CONVERTE, each edge SHALL perform one double-dabble step on the low 14 magnitude bits, MSB first: add 3 to every BCD nibble >= 5, then shift left by one.
REQ-007 After the 14th step the FSM SHALL enter ATUALIZA; after one edge in ATUALIZA it SHALL return to OCIOSO.
REQ-008 Latency: for a strobe sampled at edge k, the displays SHALL take their new value at edge k+15.
REQ-009 ocupado SHALL be 1 exactly when the state is CONVERTE or ATUALIZA.
REQ-010 The display registers SHALL change only on the ATUALIZA edge, so a display never shows a partial result.
REQ-011 A strobe during CONVERTE or ATUALIZA SHALL abort the current conversion and restart from REQ-004 with the new value (latest wins); the aborted value SHALL never be displayed.
REQ-012 Leading-zero blanking: display1..3 SHALL show blank (7'b1111111) when that digit and all more-significant digits are zero; display0 SHALL always show its digit.
REQ-013 Negative, non-overflow values SHALL set display_sinal = 7'b0111111 (segment g only); otherwise display_sinal SHALL be blank.
REQ-014 Overflow values SHALL set display0..3 to 7'b0111111 and display_sinal to blank, with the same latency as REQ-008.
REQ-015 Digit patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bit6..bit0).
REQ-016 In OCIOSO with no strobe, all outputs SHALL hold their values indefinitely.

Reset
REQ-017 Asserting reset SHALL immediately force: state=OCIOSO; ocupado=0; display0=1000000 ("0"); display1..3 and display_sinal blank; counter, accumulator, sign and overflow flags cleared.
REQ-018 Reset asserted mid-conversion SHALL discard the conversion; after release, no display update occurs without a new strobe.
REQ-019 The first strobe SHALL be honoured on the first rising edge after reset deasserts.

Structure
REQ-020 A shared package SHALL hold: the state encoding, the 7-bit segment constants (digits 0-9, blank, dash), the limit 9999, and the step count 14.
REQ-021 A single combinational sub-module, decodificador_7seg (4-bit BCD in, 7-bit active-low out), SHALL be instantiated four times; all sequencing SHALL remain in saida_display.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  1. Strobe 1234 -> ocupado high for 15 cycles; at edge k+15, display3..0 = 1,2,3,4 and sign blank.
  2. Strobe -56 -> display3,2 blank; display1=5; display0=6; display_sinal=0111111.
  3. Strobe 10000, then strobe 0x80000000 -> all four digits show dash and sign is blank, both times.
  4. Strobe 9999, then strobe 7 at cycle k+5 -> 9999 is never shown; display0=7 at k+20 with display1..3 blank.
  5. Strobe 42, reset asserted at k+8 and released at k+10 -> reset values appear immediately and remain through k+40.
  6. Strobe 0 -> display0 = 1000000 with the other digits and the sign blank; outputs hold for 100 idle cycles.
